// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: fetch state encodings and datapath-wide default sizes
`ifndef INSTR_FETCH_PKG_SV
`define INSTR_FETCH_PKG_SV
package instr_fetch_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TIMEOUT_CYCLES = 15;
  localparam int DEF_TIMEOUT_WIDTH = 4;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    READ = 2'b10,
    FULL = 2'b11
  } fetch_state_t;
endpackage
`endif

// File: rtl/instr_fetch_timeout_counter.sv
// fetch_timeout_counter: saturating READ-cycle counter, expired marks the final allowed cycle
module fetch_timeout_counter #(
  parameter int TIMEOUT_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [TIMEOUT_WIDTH-1:0] LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_WIDTH-1:0] count;
  assign expired = count >= LAST;
  always_ff @(posedge clock)
    count <= (reset || clear) ? '0 : (enable && count != '1) ? count + 1'b1 : count;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC-to-memory fetch sequencer holding one instruction until the decoder acks it
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic                  pc_oe_n,
  output logic                  pc_inc,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] ir_out,
  output logic                  ir_valid,
  input  logic                  ir_ack,
  output logic                  busy,
  output logic                  timeout_err
);
  fetch_state_t state;
  logic expired;
  assign pc_oe_n = state != ADDR;
  assign mem_rd = state == READ;
  assign busy = state == ADDR || state == READ;
  assign ir_valid = state == FULL;
  // zero the count in the same edge that leaves READ so it never lingers
  fetch_timeout_counter #(
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock(clock),
    .reset(reset),
    .clear(state != READ || abort || mem_ready || expired),
    .enable(state == READ),
    .expired(expired)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pc_inc <= 1'b0;
      mem_addr <= '0;
      ir_out <= '0;
      timeout_err <= 1'b0;
    end else begin
      pc_inc <= 1'b0;
      case (state)
        IDLE: if (fetch_req) begin
          state <= ADDR;
          timeout_err <= 1'b0;
        end
        ADDR: begin
          state <= abort ? IDLE : READ;
          if (!abort) mem_addr <= pc_in;
        end
        READ: if (abort) state <= IDLE;
        else if (mem_ready) begin
          state <= FULL;
          ir_out <= mem_data;
          pc_inc <= 1'b1;
        end else if (expired) begin
          state <= IDLE;
          timeout_err <= 1'b1;
        end
        FULL: if (abort || ir_ack) state <= (!abort && fetch_req) ? ADDR : IDLE;
      endcase
    end
  end
endmodule
